apb_regbank: RTL and testbench

Parametrised APB4 register-bank slave with NREGS word registers. Each bit is configured as read/write, read-only or write-1-to-clear, and the bank supports byte strobes, programmable wait states and error response. It sits between the APB interconnect and block-level control/status logic, driving register contents out flat and taking hardware status-set pulses in. It is the generalised successor to the fixed ten-register APB slave.

---
 rtl/apb_regbank.sv | 86 ++++++++
 tb/tb_apb_regbank.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/apb_regbank.sv
// apb_regbank: APB4 register bank with per-bit RW/RO/W1C fields, byte strobes,
// programmable wait states and an error response for bad addresses.
module apb_regbank #(
  parameter int ADDRW = 12,
  parameter int DATAW = 32,
  parameter int NREGS = 16,
  parameter int WAIT_CYC = 0,
  parameter logic [NREGS*DATAW-1:0] RST_VAL = '0,
  parameter logic [NREGS*DATAW-1:0] WMASK = '1,
  parameter logic [NREGS*DATAW-1:0] W1CMASK = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ADDRW-1:0]       paddr,
  input  logic                   psel,
  input  logic                   penable,
  input  logic                   pwrite,
  input  logic [DATAW-1:0]       pwdata,
  input  logic [DATAW/8-1:0]     pstrb,
  output logic [DATAW-1:0]       prdata,
  output logic                   pready,
  output logic                   pslverr,
  input  logic [NREGS*DATAW-1:0] hw_set,
  output logic [NREGS*DATAW-1:0] reg_q
);
  localparam int NB = DATAW / 8;
  localparam int LSB = $clog2(NB);
  localparam int IW = NREGS > 1 ? $clog2(NREGS) : 1;
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t state;
  logic [3:0] wcnt;
  logic [IW-1:0] idx_q;
  logic err_q;
  logic [DATAW-1:0] regs [NREGS];
  logic [DATAW-1:0] nxt [NREGS];
  logic [ADDRW-1:0] idx;
  logic err, setup, done, commit;
  logic [DATAW-1:0] lane, rd;
  assign idx = paddr >> LSB;
  assign err = idx >= ADDRW'(NREGS) || (paddr & ADDRW'(NB - 1)) != '0;
  assign pready = state == ACCESS && wcnt == '0;
  assign pslverr = pready && err_q;
  assign setup = state == IDLE && psel && !penable;
  assign done = state == ACCESS && psel && penable && pready;
  assign commit = done && pwrite && !err_q;
  // Hardware set is applied after the software update so a simultaneous set wins.
  function automatic logic [DATAW-1:0] upd(input logic [DATAW-1:0] r, wm, cm, hs, ln, wd,
                                           input logic en);
    logic [DATAW-1:0] w, c;
    w = en ? wm & ~cm & ln : '0;
    c = en ? cm & ln & wd : '0;
    return ((r & ~w) | (wd & w)) & ~c | (hs & cm);
  endfunction
  always_comb begin
    for (int b = 0; b < DATAW; b++) lane[b] = pstrb[b/8];
    rd = '0;
    for (int i = 0; i < NREGS; i++) begin
      nxt[i] = upd(regs[i], WMASK[i*DATAW +: DATAW], W1CMASK[i*DATAW +: DATAW],
                   hw_set[i*DATAW +: DATAW], lane, pwdata, commit && idx_q == IW'(i));
      if (idx == ADDRW'(i)) rd = regs[i] | (hw_set[i*DATAW +: DATAW] & W1CMASK[i*DATAW +: DATAW]);
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      wcnt <= '0;
      idx_q <= '0;
      err_q <= 1'b0;
      prdata <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= RST_VAL[i*DATAW +: DATAW];
    end else begin
      for (int i = 0; i < NREGS; i++) regs[i] <= nxt[i];
      if (setup) begin
        state <= ACCESS;
        wcnt <= 4'(WAIT_CYC);
        idx_q <= idx[IW-1:0];
        err_q <= err;
        prdata <= (err || pwrite) ? '0 : rd;
      end else if (state == ACCESS && (!psel || done)) begin
        state <= IDLE;
        wcnt <= '0;
        prdata <= '0;
      end else if (wcnt != '0) wcnt <= wcnt - 4'd1;
    end
  for (genvar g = 0; g < NREGS; g++) assign reg_q[g*DATAW +: DATAW] = regs[g];
endmodule

// File: tb/tb_apb_regbank.sv
// tb_apb_regbank: randomized APB traffic and hardware set pulses checked against a
// bit-rule register model, with directed literal cases for strobes, W1C, errors and aborts.
module tb_apb_regbank;
  localparam int WAIT = 3;
  function automatic logic [31:0] rst_w(input int i);
    return i == 0 ? 32'hDEAD1234 : i == 6 ? 32'h30300000 : i == 7 ? 32'hCAFEF00D :
           (i == 2 || i == 5) ? 32'h0 : 32'h11111111 * i;
  endfunction
  function automatic logic [31:0] wm_w(input int i);
    return i == 0 ? 32'h0000FFFF : i == 7 ? 32'h0 : 32'hFFFFFFFF;
  endfunction
  function automatic logic [31:0] w1c_w(input int i);
    return i == 5 ? 32'h000000FF : i == 6 ? 32'hF0F0F0F0 : 32'h0;
  endfunction
  function automatic logic [511:0] pack(input int k);
    logic [511:0] p;
    for (int i = 0; i < 16; i++) p[i*32 +: 32] = k == 0 ? rst_w(i) : k == 1 ? wm_w(i) : w1c_w(i);
    return p;
  endfunction
  logic clk, rst_n, psel, penable, pwrite, pready, pslverr;
  logic [11:0] paddr;
  logic [31:0] pwdata, prdata;
  logic [3:0] pstrb;
  logic [511:0] hw_set, reg_q;
  logic [31:0] m [16];
  logic commit, hw_en;
  logic [3:0] c_idx, c_s;
  logic [31:0] c_d, rv;
  int n_chk, n_err;
  apb_regbank #(.ADDRW(12), .DATAW(32), .NREGS(16), .WAIT_CYC(WAIT),
    .RST_VAL(pack(0)), .WMASK(pack(1)), .W1CMASK(pack(2))) dut (
    .clk(clk), .rst_n(rst_n), .paddr(paddr), .psel(psel), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .hw_set(hw_set), .reg_q(reg_q));
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  // Register model: each bit follows the RW / RO / W1C rule, then hardware set wins.
  function automatic logic [31:0] mnext(input int i, input logic [31:0] v, input logic cm,
                                        input logic [31:0] d, input logic [3:0] s, input logic [31:0] hs);
    logic [31:0] wm, cw, r;
    wm = wm_w(i);
    cw = w1c_w(i);
    r = v;
    for (int b = 0; b < 32; b++) begin
      if (cm && s[b/8] && cw[b] && d[b]) r[b] = 1'b0;
      else if (cm && s[b/8] && !cw[b] && wm[b]) r[b] = d[b];
      if (cw[b] && hs[b]) r[b] = 1'b1;
    end
    return r;
  endfunction
  always @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < 16; i++) m[i] <= rst_w(i);
    else for (int i = 0; i < 16; i++) m[i] <= mnext(i, m[i], commit && c_idx == 4'(i), c_d, c_s, hw_set[i*32 +: 32]);
  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 16; i++) chk("reg_q", reg_q[i*32 +: 32], m[i]);
    if (!psel || !rst_n) begin
      chk("idle_pready", pready, 0);
      chk("idle_pslverr", pslverr, 0);
      chk("idle_prdata", prdata, 0);
    end
  end
  function automatic logic [511:0] rnd_hw();
    logic [511:0] h;
    for (int i = 0; i < 16; i++) h[i*32 +: 32] = $urandom & $urandom & $urandom;
    return h;
  endfunction
  task automatic step();
    @(negedge clk);
    hw_set = hw_en ? rnd_hw() : '0;
  endtask
  task automatic xfer(input logic [11:0] a, input logic wr, input logic [31:0] d, input logic [3:0] s,
                      input int ab, input logic [511:0] hwd, output logic [31:0] r);
    logic e;
    logic [31:0] ex;
    r = '0;
    e = a[1:0] != 2'b0 || a >= 12'd64;
    step();
    psel = 1; penable = 0; paddr = a; pwrite = wr; pwdata = d; pstrb = wr ? s : 4'h0;
    for (int k = 0; k <= WAIT; k++) begin
      step();
      if (k == ab) begin
        psel = 0; penable = 0; pwrite = 0;
        return;
      end
      penable = 1;
      if (k == 0) ex = (e || wr) ? 32'h0 : m[a[5:2]];
      if (k == WAIT) begin
        hw_set = hw_set | hwd;
        c_idx = a[5:2]; c_d = d; c_s = s; commit = wr && !e;
      end
      chk("pready", pready, k == WAIT);
      chk("pslverr", pslverr, k == WAIT && e);
      chk("prdata", prdata, ex);
    end
    r = prdata;
    step();
    psel = 0; penable = 0; pwrite = 0; commit = 0;
  endtask
  initial begin
    n_chk = 0; n_err = 0; hw_en = 0; commit = 0; c_idx = 0; c_d = 0; c_s = 0;
    rst_n = 0; psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0; pstrb = 0; hw_set = '0;
    repeat (3) step();
    rst_n = 1;
    for (int i = 0; i < 16; i++) begin
      xfer(12'(i * 4), 0, 0, 0, -1, '0, rv);
      if (i == 0) chk("lit_rst0", rv, 32'hDEAD1234);
      if (i == 7) chk("lit_rst7", rv, 32'hCAFEF00D);
    end
    xfer(12'h8, 1, 32'h0, 4'hF, -1, '0, rv);
    xfer(12'h8, 1, 32'hAABBCCDD, 4'b0101, -1, '0, rv);
    xfer(12'h8, 0, 0, 0, -1, '0, rv);
    chk("lit_strobe", rv, 32'h00BB00DD);
    xfer(12'h0, 1, 32'hFFFFFFFF, 4'hF, -1, '0, rv);
    xfer(12'h0, 0, 0, 0, -1, '0, rv);
    chk("lit_readonly", rv, 32'hDEADFFFF);
    step();
    hw_set[5*32+3] = 1'b1;
    xfer(12'h14, 0, 0, 0, -1, '0, rv);
    chk("lit_hwset", rv, 32'h8);
    xfer(12'h14, 1, 32'h8, 4'hF, -1, '0, rv);
    xfer(12'h14, 0, 0, 0, -1, '0, rv);
    chk("lit_w1c", rv, 32'h0);
    xfer(12'h14, 1, 32'h8, 4'hF, -1, 512'(1) << (5*32+3), rv);
    xfer(12'h14, 0, 0, 0, -1, '0, rv);
    chk("lit_collide", rv, 32'h8);
    xfer(12'h40, 1, 32'hFFFFFFFF, 4'hF, -1, '0, rv);
    xfer(12'h2, 1, 32'h0, 4'hF, -1, '0, rv);
    xfer(12'h2, 0, 0, 0, -1, '0, rv);
    chk("lit_err_rd", rv, 32'h0);
    xfer(12'h0, 0, 0, 0, -1, '0, rv);
    chk("lit_err_nowr", rv, 32'hDEADFFFF);
    xfer(12'h4, 1, 32'h55, 4'hF, 2, '0, rv);
    step();
    xfer(12'h4, 0, 0, 0, -1, '0, rv);
    chk("lit_abandon", rv, 32'h11111111);
    step();
    psel = 1; penable = 0; paddr = 12'hC; pwrite = 1; pwdata = 32'hFFFF0000; pstrb = 4'hF;
    repeat (WAIT + 1) begin
      step();
      penable = 1;
    end
    chk("mid_pready_before", pready, 1);
    rst_n = 0;
    #1;
    chk("mid_pready", pready, 0);
    chk("mid_pslverr", pslverr, 0);
    chk("mid_prdata", prdata, 0);
    chk("mid_reg3", reg_q[3*32 +: 32], 32'h33333333);
    step();
    psel = 0; penable = 0; pwrite = 0;
    step();
    rst_n = 1;
    hw_en = 1;
    for (int n = 0; n < 300; n++) begin
      logic [11:0] a;
      a = $urandom_range(0, 9) == 0 ? 12'($urandom) : 12'($urandom_range(0, 15) * 4);
      xfer(a, 1'($urandom), $urandom, 4'($urandom),
           $urandom_range(0, 7) == 0 ? int'($urandom_range(0, WAIT)) : -1,
           $urandom_range(0, 3) == 0 ? rnd_hw() : '0, rv);
    end
    hw_en = 0;
    repeat (2) step();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
